// File: rtl/eth_tx_arbiter_if.sv
// Handshake bundle between the tx packet sources, the tx output switch and the arbiter.
// Pure wiring, no latency.
// Backpressure is carried by i_tx_rdy; the arbiter only observes it.
interface eth_tx_arbiter_if;
  logic       i_arp_vld;
  logic       i_arp_sop;
  logic       i_udp_vld;
  logic       i_udp_sop;
  logic       i_ping_vld;
  logic       i_ping_sop;
  logic       i_tx_vld;
  logic       i_tx_eop;
  logic       i_tx_sop;
  logic       i_tx_rdy;
  logic [1:0] o_pkt_type;
  logic       o_busy;
  logic       o_timeout;
  logic       o_sop_err;

  // Sources/switch side: drives requests and the muxed tx beat, reads the select.
  modport master (
    output i_arp_vld, i_arp_sop, i_udp_vld, i_udp_sop, i_ping_vld, i_ping_sop,
    output i_tx_vld, i_tx_eop, i_tx_sop, i_tx_rdy,
    input  o_pkt_type, o_busy, o_timeout, o_sop_err
  );

  // Arbiter side.
  modport slave (
    input  i_arp_vld, i_arp_sop, i_udp_vld, i_udp_sop, i_ping_vld, i_ping_sop,
    input  i_tx_vld, i_tx_eop, i_tx_sop, i_tx_rdy,
    output o_pkt_type, o_busy, o_timeout, o_sop_err
  );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Round-robin packet arbiter (ARP/UDP/PING) driving the tx switch select, with idle gap and stall watchdog.
// Latency: request sampled at edge N -> o_pkt_type valid after edge N; all outputs registered.
// Backpressure: grant held across i_tx_rdy stalls until eop or watchdog expiry; waiting sources hold sop.
module eth_tx_arbiter #(
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1024,
  parameter int TO_W       = 11
) (
  input logic            clk,
  input logic            rst_n,
  eth_tx_arbiter_if.slave bus
);

  localparam logic [1:0] PT_NONE = 2'd0;
  localparam logic [1:0] PT_ARP  = 2'd1;
  localparam logic [1:0] PT_UDP  = 2'd2;
  localparam logic [1:0] PT_PING = 2'd3;

  localparam logic [3:0]      GAP_LAST = 4'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      pkt_q, pkt_d;
  logic [1:0]      last_q, last_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic            sop_err_q, sop_err_d;
  logic [TO_W-1:0] stall_q, stall_d;
  logic [3:0]      gap_q, gap_d;
  logic            first_q, first_d;

  logic       req_arp, req_udp, req_ping;
  logic       acc;
  logic       grant_vld;
  logic [1:0] grant_type;

  assign req_arp  = bus.i_arp_vld  && bus.i_arp_sop;
  assign req_udp  = bus.i_udp_vld  && bus.i_udp_sop;
  assign req_ping = bus.i_ping_vld && bus.i_ping_sop;
  assign acc      = bus.i_tx_vld   && bus.i_tx_rdy;

  // Round-robin pick: first requester after the last-granted source, order ARP->UDP->PING.
  always_comb begin
    grant_vld  = req_arp || req_udp || req_ping;
    grant_type = PT_NONE;
    case (last_q)
      PT_ARP: begin
        if (req_udp)       grant_type = PT_UDP;
        else if (req_ping) grant_type = PT_PING;
        else if (req_arp)  grant_type = PT_ARP;
      end
      PT_UDP: begin
        if (req_ping)      grant_type = PT_PING;
        else if (req_arp)  grant_type = PT_ARP;
        else if (req_udp)  grant_type = PT_UDP;
      end
      default: begin
        if (req_arp)       grant_type = PT_ARP;
        else if (req_udp)  grant_type = PT_UDP;
        else if (req_ping) grant_type = PT_PING;
      end
    endcase
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d   = state_q;
    pkt_d     = pkt_q;
    last_d    = last_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    sop_err_d = 1'b0;
    stall_d   = stall_q;
    gap_d     = gap_q;
    first_d   = first_q;
    case (state_q)
      BUSY: begin
        if (acc) begin
          stall_d = '0;
          first_d = 1'b0;
          if (bus.i_tx_sop && !first_q) sop_err_d = 1'b1;
          if (bus.i_tx_eop) begin
            state_d = GAP;
            pkt_d   = PT_NONE;
            busy_d  = 1'b0;
            gap_d   = '0;
          end
        end else if (TIMEOUT != 0) begin
          stall_d = stall_q + 1'b1;
          if (stall_q == TO_LAST) begin
            state_d   = GAP;
            pkt_d     = PT_NONE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
            gap_d     = '0;
            stall_d   = '0;
          end
        end
      end
      GAP: begin
        pkt_d  = PT_NONE;
        busy_d = 1'b0;
        gap_d  = gap_q + 4'd1;
        // The final gap cycle also arbitrates, so the line sees exactly GAP_CYCLES idle cycles.
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
          if (grant_vld) begin
            state_d = BUSY;
            pkt_d   = grant_type;
            last_d  = grant_type;
            busy_d  = 1'b1;
            stall_d = '0;
            first_d = 1'b1;
          end
        end
      end
      default: begin
        pkt_d  = PT_NONE;
        busy_d = 1'b0;
        if (grant_vld) begin
          state_d = BUSY;
          pkt_d   = grant_type;
          last_d  = grant_type;
          busy_d  = 1'b1;
          stall_d = '0;
          first_d = 1'b1;
        end
      end
    endcase
  end

  // State and output registers; reset aborts any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pkt_q     <= PT_NONE;
      last_q    <= PT_PING;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      sop_err_q <= 1'b0;
      stall_q   <= '0;
      gap_q     <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      sop_err_q <= sop_err_d;
      stall_q   <= stall_d;
      gap_q     <= gap_d;
      first_q   <= first_d;
    end
  end

  assign bus.o_pkt_type = pkt_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_sop_err  = sop_err_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter (GAP_CYCLES=1, TIMEOUT=16).
// Inputs are driven 1 ns after a rising edge; outputs are compared 1 ns after the next one.
// Input vector bits: {arp_vld,arp_sop, udp_vld,udp_sop, ping_vld,ping_sop, tx_vld,tx_sop,tx_eop, tx_rdy}.
module tb_eth_tx_arbiter;

  logic clk;
  logic rst_n;

  eth_tx_arbiter_if bus ();

  eth_tx_arbiter #(.GAP_CYCLES(1), .TIMEOUT(16), .TO_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    int         tid;
    logic [9:0] in;
    logic [4:0] exp;  // {pkt_type[1:0], busy, timeout, sop_err}
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [4:0] ex(input int t, input bit b, input bit to, input bit se);
    logic [1:0] tt;
    tt = 2'(t);
    return {tt, b, to, se};
  endfunction

  task automatic add(input int tid, input logic [9:0] in, input logic [4:0] exp);
    vec_t v;
    v.rst = 1'b0; v.tid = tid; v.in = in; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic add_rst(input int tid, input logic [9:0] in, input logic [4:0] exp);
    vec_t v;
    v.rst = 1'b1; v.tid = tid; v.in = in; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [9:0] in);
    bus.i_arp_vld  = in[9];
    bus.i_arp_sop  = in[8];
    bus.i_udp_vld  = in[7];
    bus.i_udp_sop  = in[6];
    bus.i_ping_vld = in[5];
    bus.i_ping_sop = in[4];
    bus.i_tx_vld   = in[3];
    bus.i_tx_sop   = in[2];
    bus.i_tx_eop   = in[1];
    bus.i_tx_rdy   = in[0];
  endtask

  task automatic compare(input string name, input int idx, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got type=%0d busy=%b to=%b serr=%b, want type=%0d busy=%b to=%b serr=%b",
               name, idx, got[4:3], got[2], got[1], got[0], want[4:3], want[2], want[1], want[0]);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.o_pkt_type, bus.o_busy, bus.o_timeout, bus.o_sop_err};
  endfunction

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic apply(input int tid, input int idx, input logic [9:0] in, input logic [4:0] exp);
    logic [4:0] want;
    drive(in);
    sb.push_back(exp);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    compare($sformatf("t%0d", tid), idx, outs(), want);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
  task automatic pulse_reset(input int tid);
    rst_n = 1'b0;
    #3;
    compare($sformatf("t%0d_async_rst", tid), 0, outs(), ex(0, 0, 0, 0));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    drive(10'b0);

    // Test 1: lone ARP request, 3-beat packet, one gap cycle, back to idle.
    for (int i = 0; i < 4; i++) add(1, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    add(1, 10'b11_00_00_000_1, ex(1, 1, 0, 0));
    add(1, 10'b11_00_00_110_1, ex(1, 1, 0, 0));
    add(1, 10'b10_00_00_100_1, ex(1, 1, 0, 0));
    add(1, 10'b10_00_00_101_1, ex(0, 0, 0, 0));
    add(1, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    add(1, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    // Test 2: all three requesting, 2-beat packets, order ARP UDP PING ARP, one idle cycle between.
    add_rst(2, 10'b11_11_11_000_1, ex(1, 1, 0, 0));
    add(2, 10'b11_11_11_110_1, ex(1, 1, 0, 0));
    add(2, 10'b10_11_11_101_1, ex(0, 0, 0, 0));
    add(2, 10'b11_11_11_000_1, ex(2, 1, 0, 0));
    add(2, 10'b11_11_11_110_1, ex(2, 1, 0, 0));
    add(2, 10'b11_10_11_101_1, ex(0, 0, 0, 0));
    add(2, 10'b11_11_11_000_1, ex(3, 1, 0, 0));
    add(2, 10'b11_11_11_110_1, ex(3, 1, 0, 0));
    add(2, 10'b11_11_10_101_1, ex(0, 0, 0, 0));
    add(2, 10'b11_11_11_000_1, ex(1, 1, 0, 0));
    add(2, 10'b11_00_00_110_1, ex(1, 1, 0, 0));
    add(2, 10'b10_00_00_101_1, ex(0, 0, 0, 0));
    add(2, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    add(2, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    // Test 4: PING valid without sop is not a request; with sop it is granted.
    for (int i = 0; i < 3; i++) add(4, 10'b00_00_10_000_1, ex(0, 0, 0, 0));
    add(4, 10'b00_00_11_000_1, ex(3, 1, 0, 0));
    add(4, 10'b00_00_11_110_1, ex(3, 1, 0, 0));
    add(4, 10'b00_00_10_101_1, ex(0, 0, 0, 0));
    add(4, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    // Test 5: sop on beat 2 pulses sop_err once; source dropping vld does not release the grant.
    add(5, 10'b00_11_00_000_1, ex(2, 1, 0, 0));
    add(5, 10'b00_11_00_110_1, ex(2, 1, 0, 0));
    add(5, 10'b00_11_00_110_1, ex(2, 1, 0, 1));
    add(5, 10'b00_00_00_000_1, ex(2, 1, 0, 0));
    add(5, 10'b00_10_00_100_1, ex(2, 1, 0, 0));
    add(5, 10'b00_10_00_101_1, ex(0, 0, 0, 0));
    add(5, 10'b00_00_00_000_1, ex(0, 0, 0, 0));
    // Test 7: single-beat packet (sop and eop together) is legal.
    add(7, 10'b11_00_00_000_1, ex(1, 1, 0, 0));
    add(7, 10'b11_00_00_111_1, ex(0, 0, 0, 0));
    add(7, 10'b00_00_00_000_1, ex(0, 0, 0, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    compare("reset", 0, outs(), ex(0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_reset(vecs[i].tid);
      apply(vecs[i].tid, i, vecs[i].in, vecs[i].exp);
    end

    // Test 3: UDP stalls with rdy low; watchdog fires on the 16th stall cycle, PING granted after the gap.
    apply(3, 0, 10'b00_11_00_000_1, ex(2, 1, 0, 0));
    apply(3, 1, 10'b00_11_00_110_1, ex(2, 1, 0, 0));
    for (int k = 1; k <= 20; k++) begin
      logic [4:0] e;
      if (k < 16)       e = ex(2, 1, 0, 0);
      else if (k == 16) e = ex(0, 0, 1, 0);
      else              e = ex(3, 1, 0, 0);
      apply(3, 1 + k, 10'b00_10_11_100_0, e);
    end
    apply(3, 22, 10'b00_00_10_111_1, ex(0, 0, 0, 0));
    apply(3, 23, 10'b00_00_00_000_1, ex(0, 0, 0, 0));

    // Test 6: reset mid-packet clears immediately; afterwards UDP wins alone, ARP wins a tie.
    apply(6, 0, 10'b11_00_00_000_1, ex(1, 1, 0, 0));
    apply(6, 1, 10'b11_00_00_110_1, ex(1, 1, 0, 0));
    apply(6, 2, 10'b10_00_00_100_1, ex(1, 1, 0, 0));
    drive(10'b00_11_00_000_1);
    pulse_reset(6);
    apply(6, 3, 10'b00_11_00_000_1, ex(2, 1, 0, 0));
    apply(6, 4, 10'b00_11_00_111_1, ex(0, 0, 0, 0));
    pulse_reset(6);
    apply(6, 5, 10'b11_11_00_000_1, ex(1, 1, 0, 0));
    apply(6, 6, 10'b11_00_00_111_1, ex(0, 0, 0, 0));
    apply(6, 7, 10'b00_00_00_000_1, ex(0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
